alu_issue_stage: RTL

//  ID->EX driver of the ALU interface: decodes a MIPS instruction into the 5-bit ALUOp, selects In1/In2, registers them.

---
 rtl/alu_issue_pkg.sv | 69 ++++++
 rtl/alu_issue_if.sv | 33 +++
 rtl/alu_op_decoder.sv | 113 +++++++++++
 rtl/alu_issue_stage.sv | 47 ++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared constants and decode-result layout for the ALU issue stage.
// Decoder behaviour for unsupported encodings depends on ISSUE_ILLEGAL_TRAP_EN.
package alu_issue_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  // ALUOp: low nibble selects the function, bit 4 marks the signed variant.
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_AND    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_XOR    = 5'd4;
  localparam logic [4:0] ALU_NOR    = 5'd5;
  localparam logic [4:0] ALU_SLL    = 5'd6;
  localparam logic [4:0] ALU_SHR    = 5'd7;
  localparam logic [4:0] ALU_SLT    = 5'd8;
  localparam logic [4:0] ALU_EQ     = 5'd9;
  localparam logic [4:0] ALU_NE     = 5'd10;
  localparam logic [4:0] ALU_LEZ    = 5'd11;
  localparam logic [4:0] ALU_GTZ    = 5'd12;
  localparam logic [4:0] ALU_LTZ    = 5'd13;
  localparam logic [4:0] ALU_SIGNED = 5'h10;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  typedef struct packed {
    logic [4:0]        op;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [REG_AW-1:0] dst;
    logic              reg_write;
    logic              branch;
    logic              illegal;
  } dec_t;

endpackage

// File: rtl/alu_issue_if.sv
// ID->EX issue bundle. Handshake: an instruction moves from ID into the EX
// register on a clock edge where id_valid=1 and id_ready=1 (id_ready = !ex_stall).
interface alu_issue_if;
  import alu_issue_pkg::*;

  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_instr;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic              ex_stall;
  logic              ex_flush;
  logic              ex_valid;
  logic [4:0]        ex_alu_op;
  logic [DATA_W-1:0] ex_in1;
  logic [DATA_W-1:0] ex_in2;
  logic [REG_AW-1:0] ex_dst;
  logic              ex_reg_write;
  logic              ex_branch;
  logic              ex_illegal;

  modport master (
    output id_valid, id_instr, id_rs_data, id_rt_data, ex_stall, ex_flush,
    input  id_ready, ex_valid, ex_alu_op, ex_in1, ex_in2, ex_dst,
           ex_reg_write, ex_branch, ex_illegal
  );

  modport slave (
    input  id_valid, id_instr, id_rs_data, id_rt_data, ex_stall, ex_flush,
    output id_ready, ex_valid, ex_alu_op, ex_in1, ex_in2, ex_dst,
           ex_reg_write, ex_branch, ex_illegal
  );
endinterface

// File: rtl/alu_op_decoder.sv
// Combinational MIPS -> ALUOp decode with operand selection.
// ISSUE_ILLEGAL_TRAP_EN: flag unsupported encodings on illegal instead of a silent NOP.
module alu_op_decoder
  import alu_issue_pkg::*;
(
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  output dec_t              dec
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rt_f;
  logic [REG_AW-1:0] rd_f;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] imm_z;
  logic              legal;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rt_f   = instr[20:16];
  assign rd_f   = instr[15:11];
  assign shamt  = instr[10:6];
  assign imm_s  = {{(DATA_W-16){instr[15]}}, instr[15:0]};
  assign imm_z  = {{(DATA_W-16){1'b0}}, instr[15:0]};

  always_comb begin
    dec       = '0;
    dec.in1   = rs;
    dec.in2   = rt;
    legal     = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        dec.dst       = rd_f;
        dec.reg_write = 1'b1;
        case (funct)
          F_ADD, F_ADDU: dec.op = ALU_ADD;
          F_SUB, F_SUBU: dec.op = ALU_SUB;
          F_AND:         dec.op = ALU_AND;
          F_OR:          dec.op = ALU_OR;
          F_XOR:         dec.op = ALU_XOR;
          F_NOR:         dec.op = ALU_NOR;
          F_SLT:         dec.op = ALU_SLT | ALU_SIGNED;
          F_SLTU:        dec.op = ALU_SLT;
          F_SLL:  begin dec.op = ALU_SLL;              dec.in1 = {{(DATA_W-5){1'b0}}, shamt}; end
          F_SRL:  begin dec.op = ALU_SHR;              dec.in1 = {{(DATA_W-5){1'b0}}, shamt}; end
          F_SRA:  begin dec.op = ALU_SHR | ALU_SIGNED; dec.in1 = {{(DATA_W-5){1'b0}}, shamt}; end
          F_SLLV: begin dec.op = ALU_SLL;              dec.in1 = {{(DATA_W-5){1'b0}}, rs[4:0]}; end
          F_SRLV: begin dec.op = ALU_SHR;              dec.in1 = {{(DATA_W-5){1'b0}}, rs[4:0]}; end
          F_SRAV: begin dec.op = ALU_SHR | ALU_SIGNED; dec.in1 = {{(DATA_W-5){1'b0}}, rs[4:0]}; end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        dec.op        = ALU_ADD;
        dec.in2       = imm_s;
        dec.dst       = rt_f;
        dec.reg_write = (opcode != OP_SW);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec.op        = (opcode == OP_ANDI) ? ALU_AND : (opcode == OP_ORI) ? ALU_OR : ALU_XOR;
        dec.in2       = imm_z;
        dec.dst       = rt_f;
        dec.reg_write = 1'b1;
      end
      OP_SLTI, OP_SLTIU: begin
        dec.op        = (opcode == OP_SLTI) ? (ALU_SLT | ALU_SIGNED) : ALU_SLT;
        dec.in2       = imm_s;
        dec.dst       = rt_f;
        dec.reg_write = 1'b1;
      end
      OP_LUI: begin
        // The ALU builds imm<<16 as a left shift by a constant 16.
        dec.op        = ALU_SLL;
        dec.in1       = DATA_W'(16);
        dec.in2       = imm_z;
        dec.dst       = rt_f;
        dec.reg_write = 1'b1;
      end
      OP_BEQ:  begin dec.op = ALU_EQ;  dec.branch = 1'b1; end
      OP_BNE:  begin dec.op = ALU_NE;  dec.branch = 1'b1; end
      OP_BLEZ: begin dec.op = ALU_LEZ; dec.branch = 1'b1; end
      OP_BGTZ: begin dec.op = ALU_GTZ; dec.branch = 1'b1; end
      OP_REGIMM: begin
        if (rt_f == '0) begin
          dec.op     = ALU_LTZ;
          dec.branch = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec.op        = ALU_ADD;
      dec.in1       = rs;
      dec.in2       = rt;
      dec.dst       = '0;
      dec.reg_write = 1'b0;
      dec.branch    = 1'b0;
    end
`ifdef ISSUE_ILLEGAL_TRAP_EN
    dec.illegal = !legal;
`else
    dec.illegal = 1'b0;
`endif
    if (dec.dst == '0) dec.reg_write = 1'b0;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX pipeline register feeding the ALU; priority reset > flush > stall > load.
// ex_illegal is only ever set when ISSUE_ILLEGAL_TRAP_EN is defined.
module alu_issue_stage
  import alu_issue_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  alu_issue_if.slave bus
);

  dec_t dec;

  alu_op_decoder u_dec (
    .instr (bus.id_instr),
    .rs    (bus.id_rs_data),
    .rt    (bus.id_rt_data),
    .dec   (dec)
  );

  assign bus.id_ready = !bus.ex_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_alu_op    <= ALU_ADD;
      bus.ex_in1       <= '0;
      bus.ex_in2       <= '0;
      bus.ex_dst       <= '0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_branch    <= 1'b0;
      bus.ex_illegal   <= 1'b0;
    end else if (bus.ex_flush) begin
      // Only the valid bit dies; the payload stays for debug visibility.
      bus.ex_valid <= 1'b0;
    end else if (!bus.ex_stall) begin
      bus.ex_valid     <= bus.id_valid;
      bus.ex_alu_op    <= dec.op;
      bus.ex_in1       <= dec.in1;
      bus.ex_in2       <= dec.in2;
      bus.ex_dst       <= dec.dst;
      bus.ex_reg_write <= bus.id_valid & dec.reg_write;
      bus.ex_branch    <= bus.id_valid & dec.branch;
      bus.ex_illegal   <= dec.illegal;
    end
  end

endmodule
